// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-item vending controller.
// Coin codes, FSM state encoding and one-hot item conversion.
package vend_pkg;

   localparam logic [1:0] COIN_5  = 2'b00;
   localparam logic [1:0] COIN_10 = 2'b01;
   localparam logic [1:0] COIN_15 = 2'b10;
   localparam logic [1:0] COIN_20 = 2'b11;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_COLLECT  = 2'd1;
   localparam logic [1:0] ST_DISPENSE = 2'd2;
   localparam logic [1:0] ST_CHANGE   = 2'd3;

   typedef enum logic [1:0] {
      IDLE     = ST_IDLE,
      COLLECT  = ST_COLLECT,
      DISPENSE = ST_DISPENSE,
      CHANGE   = ST_CHANGE
   } state_t;

   function automatic logic [2:0] coin_units(
      input logic [1:0] c
   );
      logic [2:0] u;
      unique case (c)
         COIN_5:  u = 3'd1;
         COIN_10: u = 3'd2;
         COIN_15: u = 3'd3;
         COIN_20: u = 3'd4;
         default: u = 3'd1;
      endcase
      return u;
   endfunction

   function automatic logic [7:0] onehot8(
      input logic [2:0] idx
   );
      return 8'b1 << idx;
   endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters with bulk reload and saturating
// single-index decrement; exposes the stock==0 flags.
module vend_stock_bank #(
   parameter int N_ITEMS    = 4,
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               reload,
   input  logic               dec,
   input  logic [2:0]         idx,
   output logic [N_ITEMS-1:0] empty
);

   logic [STOCK_W-1:0] cnt_q [N_ITEMS];

   always_ff @(posedge clk) begin
      if (rst || reload) begin
         for (int i = 0; i < N_ITEMS; i++)
            cnt_q[i] <= STOCK_W'(STOCK_INIT);
      end else if (dec) begin
         for (int i = 0; i < N_ITEMS; i++)
            if (idx == 3'(i) && cnt_q[i] != '0)
               cnt_q[i] <= cnt_q[i] - 1'b1;
      end
   end

   always_comb begin
      empty = '0;
      for (int i = 0; i < N_ITEMS; i++)
         empty[i] = (cnt_q[i] == '0);
   end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: credit, selection, refund, change.
// Optional idle refund in COLLECT enabled by VEND_TIMEOUT_EN.
module vend_ctrl_multi
   import vend_pkg::*;
#(
   parameter int N_ITEMS     = 4,
   parameter int CREDIT_W    = 5,
   parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES =
      {5'd4, 5'd3, 5'd2, 5'd1},
   parameter int STOCK_W     = 4,
   parameter int STOCK_INIT  = 2,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin_valid,
   input  logic [1:0]          coin,
   output logic                coin_ready,
   input  logic                sel_valid,
   input  logic [2:0]          sel,
   input  logic                cancel,
   input  logic                restock,
   output logic                dispense,
   output logic [N_ITEMS-1:0]  item,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_amt,
   output logic                deny,
   output logic [CREDIT_W-1:0] credit,
   output logic [N_ITEMS-1:0]  sold_out
);

   localparam int CREDIT_MAX = (1 << CREDIT_W) - 1;
   localparam logic [CREDIT_W-1:0] READY_LIM =
      CREDIT_W'(CREDIT_MAX - 4);

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [2:0]          sel_q, sel_d;
   logic                disp_d;
   logic [N_ITEMS-1:0]  item_d;
   logic                chg_v_d;
   logic [CREDIT_W-1:0] chg_amt_d;
   logic                deny_d;
   logic                restock_en;
   logic                dec_en;

   logic                coin_acc;
   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W-1:0] sum;
   logic [CREDIT_W-1:0] price;
   logic                avail;
   logic                buy_ok;
   logic [7:0]          oh_sel;
   logic                tmo;

   assign coin_ready = (state_q == IDLE || state_q == COLLECT)
                    && credit_q <= READY_LIM;
   assign coin_acc = coin_valid && coin_ready;
   assign coin_val = coin_acc ? CREDIT_W'(coin_units(coin)) : '0;
   assign sum      = credit_q + coin_val;
   assign oh_sel   = onehot8(sel);
   assign credit   = credit_q;

   // Out-of-range indices never match, so they fall through to deny.
   always_comb begin
      price = '0;
      avail = 1'b0;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (sel == 3'(i)) begin
            price = PRICES[i*CREDIT_W +: CREDIT_W];
            avail = !sold_out[i];
         end
      end
   end

   assign buy_ok = sel_valid && avail && credit_q >= price;

`ifdef VEND_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_q;

   always_ff @(posedge clk) begin
      if (rst || state_q != COLLECT || coin_acc || sel_valid)
         tmo_q <= '0;
      else
         tmo_q <= tmo_q + 1'b1;
   end

   assign tmo = (state_q == COLLECT)
             && (tmo_q == TW'(TIMEOUT_CYC - 1));
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      sel_d      = sel_q;
      disp_d     = 1'b0;
      item_d     = '0;
      chg_v_d    = 1'b0;
      chg_amt_d  = '0;
      deny_d     = 1'b0;
      restock_en = 1'b0;
      dec_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            restock_en = restock;
            deny_d     = sel_valid;
            if (coin_acc) begin
               credit_d = sum;
               state_d  = COLLECT;
            end
         end
         COLLECT: begin
            if (cancel || tmo) begin
               state_d   = CHANGE;
               chg_v_d   = 1'b1;
               chg_amt_d = sum;
               credit_d  = '0;
            end else if (buy_ok) begin
               state_d  = DISPENSE;
               credit_d = sum - price;
               sel_d    = sel;
               disp_d   = 1'b1;
               item_d   = oh_sel[N_ITEMS-1:0];
            end else begin
               deny_d   = sel_valid;
               credit_d = sum;
            end
         end
         DISPENSE: begin
            dec_en   = 1'b1;
            credit_d = '0;
            if (credit_q != '0) begin
               state_d   = CHANGE;
               chg_v_d   = 1'b1;
               chg_amt_d = credit_q;
            end else begin
               state_d = IDLE;
            end
         end
         CHANGE: begin
            state_d  = IDLE;
            credit_d = '0;
         end
         default: begin
            state_d  = IDLE;
            credit_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         credit_q     <= '0;
         sel_q        <= '0;
         dispense     <= 1'b0;
         item         <= '0;
         change_valid <= 1'b0;
         change_amt   <= '0;
         deny         <= 1'b0;
      end else begin
         state_q      <= state_d;
         credit_q     <= credit_d;
         sel_q        <= sel_d;
         dispense     <= disp_d;
         item         <= item_d;
         change_valid <= chg_v_d;
         change_amt   <= chg_amt_d;
         deny         <= deny_d;
      end
   end

   vend_stock_bank #(
      .N_ITEMS    (N_ITEMS),
      .STOCK_W    (STOCK_W),
      .STOCK_INIT (STOCK_INIT)
   ) u_stock (
      .clk    (clk),
      .rst    (rst),
      .reload (restock_en),
      .dec    (dec_en),
      .idx    (sel_q),
      .empty  (sold_out)
   );

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Randomized bench for vend_ctrl_multi against a transaction-level
// model: credit, stock and a queue of pending output events.
module tb_vend_ctrl_multi;

   localparam int N     = 4;
   localparam int CW    = 5;
   localparam int SINIT = 2;
`ifdef VEND_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 1000;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          coin_valid = 1'b0;
   logic [1:0]    coin = '0;
   logic          coin_ready;
   logic          sel_valid = 1'b0;
   logic [2:0]    sel = '0;
   logic          cancel = 1'b0;
   logic          restock = 1'b0;
   logic          dispense;
   logic [N-1:0]  item;
   logic          change_valid;
   logic [CW-1:0] change_amt;
   logic          deny;
   logic [CW-1:0] credit;
   logic [N-1:0]  sold_out;

   vend_ctrl_multi #(
      .N_ITEMS     (N),
      .CREDIT_W    (CW),
      .PRICES      ({5'd4, 5'd3, 5'd2, 5'd1}),
      .STOCK_W     (4),
      .STOCK_INIT  (SINIT),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .coin_valid   (coin_valid),
      .coin         (coin),
      .coin_ready   (coin_ready),
      .sel_valid    (sel_valid),
      .sel          (sel),
      .cancel       (cancel),
      .restock      (restock),
      .dispense     (dispense),
      .item         (item),
      .change_valid (change_valid),
      .change_amt   (change_amt),
      .deny         (deny),
      .credit       (credit),
      .sold_out     (sold_out)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   typedef struct {
      bit disp;
      int idx;
      bit chg;
      int amt;
   } ev_t;

   int  price_of [N] = '{1, 2, 3, 4};
   int  m_credit;
   int  m_stock [N];
   int  m_timer;
   bit  m_deny;
   ev_t cur;
   ev_t pend [$];

   function automatic void m_reset();
      m_credit = 0;
      m_timer  = 0;
      m_deny   = 0;
      cur      = '{default: 0};
      pend.delete();
      for (int i = 0; i < N; i++) m_stock[i] = SINIT;
   endfunction

   function automatic logic [N-1:0] m_sold();
      logic [N-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[i] = (m_stock[i] == 0);
      return v;
   endfunction

   task automatic step(
      input bit       cv,
      input bit [1:0] c,
      input bit       sv,
      input bit [2:0] s,
      input bit       cn,
      input bit       rs,
      input bit       r
   );
      bit  busy, ready, acc, tmo;
      int  val, rem;
      ev_t ne;
      logic [N-1:0] exp_item;
      @(negedge clk);
      coin_valid = cv; coin = c;
      sel_valid  = sv; sel  = s;
      cancel     = cn; restock = rs;
      rst        = r;
      busy  = cur.disp || cur.chg;
      ready = !busy && m_credit <= (1 << CW) - 5;
      if (!r) chk("coin_ready", 32'(coin_ready), 32'(ready));
      if (r) begin
         m_reset();
      end else begin
         ne     = '{default: 0};
         m_deny = 0;
         acc    = cv && ready;
         val    = acc ? int'(c) + 1 : 0;
         if (busy) begin
            if (pend.size() > 0) ne = pend.pop_front();
            m_timer = 0;
         end else if (m_credit == 0) begin
            m_deny = sv;
            if (rs) for (int i = 0; i < N; i++) m_stock[i] = SINIT;
            m_credit = val;
            m_timer  = 0;
         end else begin
            tmo = (m_timer == TO - 1);
            if (cn || tmo) begin
               ne.chg   = 1;
               ne.amt   = m_credit + val;
               m_credit = 0;
            end else if (sv && s < N && m_stock[s] > 0
                         && m_credit >= price_of[s]) begin
               ne.disp = 1;
               ne.idx  = int'(s);
               m_stock[s]--;
               rem = m_credit + val - price_of[s];
               if (rem > 0)
                  pend.push_back('{disp: 0, idx: 0, chg: 1, amt: rem});
               m_credit = 0;
            end else begin
               m_deny   = sv;
               m_credit = m_credit + val;
            end
            m_timer = (acc || sv) ? 0 : m_timer + 1;
         end
         cur = ne;
      end
      @(posedge clk);
      #1;
      exp_item = cur.disp ? N'(1 << cur.idx) : '0;
      chk("dispense", 32'(dispense), 32'(cur.disp));
      chk("item", 32'(item), 32'(exp_item));
      chk("change_valid", 32'(change_valid), 32'(cur.chg));
      chk("change_amt", 32'(change_amt), cur.chg ? cur.amt : 0);
      chk("deny", 32'(deny), 32'(m_deny));
      if (!(cur.disp || cur.chg)) begin
         chk("credit", 32'(credit), m_credit);
         chk("sold_out", 32'(sold_out), 32'(m_sold()));
      end
   endtask

   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic put(input bit [1:0] c);
      step(1, c, 0, 0, 0, 0, 0);
   endtask

   task automatic pick(input bit [2:0] s);
      step(0, 0, 1, s, 0, 0, 0);
   endtask

   initial begin
      m_reset();
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("rst_credit", 32'(credit), 0);
      chk("rst_sold", 32'(sold_out), 0);

      put(2'b01); put(2'b01);
      chk("buy_credit", 32'(credit), 4);
      pick(3'd1);
      chk("buy_item", 32'(item), 32'b0010);
      quiet(1);
      chk("buy_change", 32'(change_amt), 2);
      quiet(2);

      for (int k = 0; k < 2; k++) begin
         put(2'b00); pick(3'd0); quiet(2);
      end
      put(2'b00); pick(3'd0);
      chk("so_deny", 32'(deny), 1);
      chk("so_flag", 32'(sold_out[0]), 1);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("so_refund", 32'(change_amt), 1);
      quiet(1);
      step(0, 0, 0, 0, 0, 1, 0);
      chk("restock", 32'(sold_out), 0);

      put(2'b00); put(2'b10);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("cancel_amt", 32'(change_amt), 4);
      quiet(2);

      for (int k = 0; k < 7; k++) put(2'b11);
      chk("full_credit", 32'(credit), 28);
      put(2'b11); put(2'b11);
      chk("full_ready", 32'(coin_ready), 0);
      pick(3'd3);
      quiet(1);
      chk("full_change", 32'(change_amt), 24);
      quiet(1);
      chk("full_ready_back", 32'(coin_ready), 1);

      put(2'b01);
      step(1, 2'b00, 1, 3'd1, 0, 0, 0);
      chk("same_item", 32'(item), 32'b0010);
      quiet(1);
      chk("same_change", 32'(change_amt), 1);
      quiet(1);

      put(2'b01); put(2'b01); pick(3'd1);
      quiet(1);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("rst_chg", 32'(change_valid), 0);
      put(2'b01); put(2'b01); pick(3'd1);
      step(0, 0, 0, 0, 0, 0, 1);
      quiet(2);

      put(2'b10);
`ifdef VEND_TIMEOUT_EN
      quiet(8);
      chk("tmo_amt", 32'(change_amt), 3);
      quiet(2);
`else
      quiet(100);
      chk("no_tmo", 32'(credit), 3);
      step(0, 0, 0, 0, 1, 0, 0);
      quiet(1);
`endif

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 9) < 4,
              2'($urandom_range(0, 3)),
              $urandom_range(0, 9) < 2,
              3'($urandom_range(0, 7)),
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 199) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
